// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one RAM port among N_CORES cores,
// one transaction in flight; loads wait MEM_LAT cycles for read data.
module mem_port_arbiter #(
   parameter int N_CORES = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int MEM_LAT = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_CORES-1:0]          req,
   input  logic [N_CORES-1:0]          we,
   input  logic [N_CORES*ADDR_W-1:0]   addr,
   input  logic [N_CORES*DATA_W-1:0]   wdata,
   output logic [N_CORES-1:0]          ack,
   output logic [N_CORES-1:0]          stall,
   output logic [DATA_W-1:0]           rdata,
   output logic                        busy,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
);
   localparam int ID_W  = $clog2(N_CORES);
   localparam int CNT_W = $clog2(MEM_LAT + 1);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
   state_t state, state_nx;
   logic [ID_W-1:0]  rr_ptr, grant_id, win, idx;
   logic [CNT_W-1:0] cnt;
   logic             found;

   // Walk the ring starting at rr_ptr; the first requester found wins.
   always_comb begin
      win   = '0;
      idx   = rr_ptr;
      found = 1'b0;
      for (int k = 0; k < N_CORES; k++) begin
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
         idx = (idx == ID_W'(N_CORES - 1)) ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      state_nx = (state == IDLE)   ? (|req ? ACCESS : IDLE) :
                 (state == ACCESS) ? (mem_we ? DONE : WAIT) :
                 (state == WAIT)   ? (cnt == '0 ? DONE : WAIT) : IDLE;
      ack = '0;
      if (state == DONE) ack[grant_id] = 1'b1;
   end

   assign mem_en = (state == ACCESS);
   assign busy   = (state != IDLE);
   assign stall  = req & ~ack;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr    <= '0;
         grant_id  <= '0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         if (state == IDLE && |req) begin
            grant_id  <= win;
            mem_we    <= we[win];
            mem_addr  <= addr[int'(win)*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[int'(win)*DATA_W +: DATA_W];
         end
         if (state == ACCESS) cnt <= CNT_W'(MEM_LAT - 1);
         if (state == WAIT) cnt <= cnt - 1'b1;
         if (state == WAIT && cnt == '0) rdata <= mem_rdata;
         if (state == DONE) rr_ptr <= (grant_id == ID_W'(N_CORES - 1)) ? '0 : grant_id + 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level timing model of the arbiter.
module tb_mem_port_arbiter;
   localparam int N = 4, AW = 32, DW = 64, LAT = 2;
   logic clk = 1'b0, reset = 1'b0;
   logic [N-1:0]    req = '0, we = '0;
   logic [N*AW-1:0] addr = '0;
   logic [N*DW-1:0] wdata = '0;
   logic [DW-1:0]   mem_rdata = '0;
   logic [N-1:0]    ack, stall;
   logic [DW-1:0]   rdata, mem_wdata;
   logic [AW-1:0]   mem_addr;
   logic            busy, mem_en, mem_we;
   int n_pass = 0, n_total = 0;
   logic [3:0] t3_exp [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1};

   mem_port_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .stall(stall), .rdata(rdata), .busy(busy), .mem_en(mem_en),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      mem_rdata = {$urandom, $urandom};
   endtask

   task automatic set_core(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[i] = w;
      addr[i*AW +: AW] = a;
      wdata[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 reset = 1'b0;
      req = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ack", ack, 0);
      chk("rst_mem_en", mem_en, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Model: a transaction is granted in an IDLE cycle (age 0); mem_en at age 1,
   // load data sampled at age 1+LAT, ack at age 2 (store) or 2+LAT (load).
   initial begin : model
      bit m_busy, m_we;
      int m_age, m_id, m_rr, d, j;
      logic [AW-1:0] m_addr;
      logic [DW-1:0] m_wdata, m_rdata;
      logic [N-1:0] e_ack;
      m_busy = 0; m_we = 0; m_age = 0; m_id = 0; m_rr = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_busy = 0; m_we = 0; m_age = 0; m_id = 0; m_rr = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
         end
         d = m_we ? 2 : 2 + LAT;
         e_ack = '0;
         if (m_busy && m_age == d) e_ack[m_id] = 1'b1;
         chk("busy", busy, m_busy);
         chk("mem_en", mem_en, m_busy && m_age == 1);
         chk("ack", ack, e_ack);
         chk("stall", stall, req & ~e_ack);
         chk("rdata", rdata, m_rdata);
         chk("mem_we", mem_we, m_we);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
         if (reset) begin
            if (!m_busy) begin
               if (|req) begin
                  j = 0;
                  for (int k = N - 1; k >= 0; k--) if (req[(m_rr + k) % N]) j = (m_rr + k) % N;
                  m_id = j; m_we = we[j];
                  m_addr = addr[j*AW +: AW];
                  m_wdata = wdata[j*DW +: DW];
                  m_busy = 1; m_age = 1;
               end
            end else if (m_age == d) begin
               m_busy = 0;
               m_rr = (m_id + 1) % N;
            end else begin
               if (!m_we && m_age == 1 + LAT) m_rdata = mem_rdata;
               m_age++;
            end
         end
      end
   end

   initial begin : stim
      logic [N-1:0] last_ack;
      @(posedge clk);
      #2;
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      // T1 store from core 0
      step(); req = 4'b0001; set_core(0, 1, 32'h40, 64'hDEAD);
      @(negedge clk); chk("t1_stall_c0", stall, 4'b0001);
      step(); @(negedge clk);
      chk("t1_mem_en", mem_en, 1); chk("t1_mem_we", mem_we, 1);
      chk("t1_mem_addr", mem_addr, 32'h40); chk("t1_mem_wdata", mem_wdata, 64'hDEAD);
      chk("t1_stall_c1", stall, 4'b0001); chk("t1_ack_c1", ack, 0);
      step(); @(negedge clk);
      chk("t1_ack", ack, 4'b0001); chk("t1_stall_c2", stall, 0);
      step(); req = '0;
      // T2 load from core 1, data returned in cycle 3
      step(); req = 4'b0010; set_core(1, 0, 32'h80, 64'h0);
      step(); step();
      step(); mem_rdata = 64'h1234;
      step(); @(negedge clk);
      chk("t2_ack", ack, 4'b0010); chk("t2_rdata", rdata, 64'h1234);
      step(); req = 4'b0100; set_core(2, 1, 32'hC0, 64'h55);
      step(); step(); @(negedge clk);
      chk("t2_store_ack", ack, 4'b0100); chk("t2_rdata_hold", rdata, 64'h1234);
      // T4 cores 3 and 0 with rr_ptr at 3
      step(); req = 4'b1001; set_core(3, 1, 32'h300, 64'h3); set_core(0, 1, 32'h100, 64'h1);
      for (int c = 0; c < 12; c++) begin
         if (c > 0) step();
         @(negedge clk);
         chk("t4_no_c12", ack[2:1], 0);
         if (c % 3 == 2) chk("t4_ack", ack, (c % 6 == 2) ? 4'b1000 : 4'b0001);
      end
      do_reset();
      // T3 full contention from reset
      step(); req = 4'b1111;
      for (int i = 0; i < N; i++) set_core(i, 1, 32'(i * 16), 64'(i + 100));
      for (int c = 0; c < 15; c++) begin
         if (c > 0) step();
         @(negedge clk);
         if (c % 3 == 2) chk("t3_ack", ack, t3_exp[c / 3]);
      end
      // T5 reset during load wait
      step(); req = 4'b0010; set_core(1, 0, 32'h84, 64'h0);
      step(); step();
      #1 chk("t5_busy_pre", busy, 1);
      #1 reset = 1'b0; req = '0;
      #1;
      chk("t5_busy", busy, 0); chk("t5_mem_en", mem_en, 0); chk("t5_ack", ack, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; req = 4'b0100; set_core(2, 1, 32'hC4, 64'h77);
      step(); step(); @(negedge clk);
      chk("t5_ack_c2", ack, 4'b0100); chk("t5_rdata", rdata, 0);
      // T6 granted core drops req mid-transaction
      step(); req = '0;
      step(); req = 4'b0100; set_core(2, 1, 32'hC8, 64'h99);
      step(); req = '0;
      @(negedge clk); chk("t6_mem_en", mem_en, 1); chk("t6_stall", stall, 0);
      step(); @(negedge clk); chk("t6_ack", ack, 4'b0100);
      step(); @(negedge clk); chk("t6_idle", busy, 0);
      // random traffic honoring the hold-until-ack protocol
      last_ack = '0;
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (req[i] && last_ack[i]) req[i] = 1'b0;
            else if (!req[i]) begin
               set_core(i, 1'($urandom), $urandom, {$urandom, $urandom});
               if ($urandom_range(2) == 0) req[i] = 1'b1;
            end
         end
         @(negedge clk);
         last_ack = ack;
      end
      for (int c = 0; c < 40 && busy; c++) begin
         step(); req = '0;
         @(negedge clk);
      end
      chk("drain_idle", busy, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
